// File: rtl/rx_serial_pkg.sv
// Shared definitions for the 7O1 serial receiver: state codes, frame geometry
// and the default bit period.
package rx_serial_pkg;

   typedef enum logic [3:0] {
      INICIAL       = 4'd0,
      PREPARACAO    = 4'd1,
      ESPERA        = 4'd2,
      AMOSTRA       = 4'd3,
      ARMAZENAMENTO = 4'd4,
      FINAL_RX      = 4'd5,
      DADO_PRESENTE = 4'd6
   } estado_t;

   localparam int FRAME_BITS       = 10;
   localparam int DATA_BITS        = 7;
   localparam int CLKS_PER_BIT_DEF = 434;

   // Odd parity holds when data plus parity bit contain an odd number of ones.
   function automatic logic paridade_impar(input logic [DATA_BITS:0] v);
      return ^v;
   endfunction

endpackage

// File: rtl/rx_serial_uc.sv
// Control unit of the 7O1 receiver: Moore FSM whose strobes are registered
// together with the state, so each strobe is high exactly while in its state.
module rx_serial_uc
   import rx_serial_pkg::*;
(
   input  logic       clk_i,
   input  logic       rst_ni,
   input  logic       tick_i,
   input  logic       linha_i,
   input  logic       inicio_i,
   input  logic       fim_i,
   input  logic       recebe_i,
   output logic       zera_o,
   output logic       conta_o,
   output logic       carrega_timer_o,
   output logic       desloca_o,
   output logic       registra_o,
   output logic       pronto_o,
   output logic [3:0] db_estado_o
);

   estado_t estado_q;
   logic    zera_q, conta_q, carrega_q, desloca_q, registra_q, pronto_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         estado_q   <= INICIAL;
         zera_q     <= 1'b0;
         conta_q    <= 1'b0;
         carrega_q  <= 1'b0;
         desloca_q  <= 1'b0;
         registra_q <= 1'b0;
         pronto_q   <= 1'b0;
      end else begin
         zera_q     <= 1'b0;
         conta_q    <= 1'b0;
         carrega_q  <= 1'b0;
         desloca_q  <= 1'b0;
         registra_q <= 1'b0;
         pronto_q   <= 1'b0;
         case (estado_q)
            INICIAL: begin
               if (!linha_i) begin
                  estado_q  <= PREPARACAO;
                  zera_q    <= 1'b1;
                  carrega_q <= 1'b1;
               end
            end
            PREPARACAO: estado_q <= ESPERA;
            ESPERA: begin
               // The bit count is stable here, so the shift decision for the
               // coming sample can be made one cycle ahead.
               if (tick_i) begin
                  estado_q  <= AMOSTRA;
                  conta_q   <= 1'b1;
                  desloca_q <= !inicio_i;
               end
            end
            AMOSTRA: begin
               if (inicio_i && linha_i) begin
                  estado_q <= INICIAL;
               end else if (fim_i) begin
                  estado_q   <= ARMAZENAMENTO;
                  registra_q <= 1'b1;
               end else begin
                  estado_q <= ESPERA;
               end
            end
            ARMAZENAMENTO: begin
               estado_q <= FINAL_RX;
               pronto_q <= 1'b1;
            end
            FINAL_RX: estado_q <= DADO_PRESENTE;
            DADO_PRESENTE: begin
               // A new start edge wins over the acknowledge (overrun).
               if (!linha_i) begin
                  estado_q  <= PREPARACAO;
                  zera_q    <= 1'b1;
                  carrega_q <= 1'b1;
               end else if (recebe_i) begin
                  estado_q <= INICIAL;
               end
            end
            default: estado_q <= INICIAL;
         endcase
      end
   end

   always_comb begin
      case (estado_q)
         INICIAL, PREPARACAO, ESPERA, AMOSTRA,
         ARMAZENAMENTO, FINAL_RX, DADO_PRESENTE: db_estado_o = estado_q;
         default:                                db_estado_o = 4'hF;
      endcase
   end

   assign zera_o          = zera_q;
   assign conta_o         = conta_q;
   assign carrega_timer_o = carrega_q;
   assign desloca_o       = desloca_q;
   assign registra_o      = registra_q;
   assign pronto_o        = pronto_q;

endmodule

// File: rtl/rx_serial_7o1.sv
// 7O1 asynchronous serial receiver: synchronizer, mid-bit timer, bit counter,
// shift register and hold-until-acknowledged output registers.
module rx_serial_7o1
   import rx_serial_pkg::*;
#(
   parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
   parameter int TIMER_W      = 9
) (
   input  logic                 clock,
   input  logic                 reset,
   input  logic                 dado_serial,
   input  logic                 recebe_dado,
   output logic [DATA_BITS-1:0] dados_ascii,
   output logic                 paridade_ok,
   output logic                 erro_quadro,
   output logic                 pronto_rx,
   output logic                 tem_dado,
   output logic [3:0]           db_estado
);

   localparam int SHIFT_W = FRAME_BITS - 1;
   localparam logic [TIMER_W-1:0] TIMER_MAX  = TIMER_W'(CLKS_PER_BIT - 1);
   // First tick lands half a bit after preparacao, i.e. mid start bit.
   localparam logic [TIMER_W-1:0] TIMER_LOAD = TIMER_W'(CLKS_PER_BIT - CLKS_PER_BIT / 2);
   localparam logic [3:0]         CNT_FIM    = 4'(FRAME_BITS - 1);

   logic                 sync1_q, sync2_q;
   logic [TIMER_W-1:0]   timer_q, timer_d;
   logic [3:0]           cnt_q, cnt_d;
   logic [SHIFT_W-1:0]   shift_q, shift_d;
   logic [DATA_BITS-1:0] dados_q, dados_d;
   logic                 par_q, par_d;
   logic                 erro_q, erro_d;
   logic                 tem_q, tem_d;

   logic linha, tick, inicio, fim;
   logic zera, conta, carrega_timer, desloca, registra, pronto;

   assign linha  = sync2_q;
   assign tick   = (timer_q == TIMER_MAX);
   assign inicio = (cnt_q == 4'd0);
   assign fim    = (cnt_q == CNT_FIM);

   rx_serial_uc u_uc (
      .clk_i           (clock),
      .rst_ni          (reset),
      .tick_i          (tick),
      .linha_i         (linha),
      .inicio_i        (inicio),
      .fim_i           (fim),
      .recebe_i        (recebe_dado),
      .zera_o          (zera),
      .conta_o         (conta),
      .carrega_timer_o (carrega_timer),
      .desloca_o       (desloca),
      .registra_o      (registra),
      .pronto_o        (pronto),
      .db_estado_o     (db_estado)
   );

   always_comb begin
      timer_d = timer_q;
      cnt_d   = cnt_q;
      shift_d = shift_q;
      dados_d = dados_q;
      par_d   = par_q;
      erro_d  = erro_q;
      tem_d   = tem_q;

      if (carrega_timer)  timer_d = TIMER_LOAD;
      else if (tick)      timer_d = '0;
      else                timer_d = timer_q + 1'b1;

      if (zera)           cnt_d = 4'd0;
      else if (conta)     cnt_d = cnt_q + 4'd1;

      if (desloca)        shift_d = {linha, shift_q[SHIFT_W-1:1]};

      if (registra) begin
         dados_d = shift_q[DATA_BITS-1:0];
         par_d   = paridade_impar(shift_q[DATA_BITS:0]);
         erro_d  = ~shift_q[SHIFT_W-1];
      end

      if (pronto) begin
         tem_d = 1'b1;
      end else if ((db_estado == 4'(DADO_PRESENTE)) && (recebe_dado || !linha)) begin
         tem_d = 1'b0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         timer_q <= '0;
         cnt_q   <= 4'd0;
         shift_q <= '0;
         dados_q <= '0;
         par_q   <= 1'b0;
         erro_q  <= 1'b0;
         tem_q   <= 1'b0;
      end else begin
         sync1_q <= dado_serial;
         sync2_q <= sync1_q;
         timer_q <= timer_d;
         cnt_q   <= cnt_d;
         shift_q <= shift_d;
         dados_q <= dados_d;
         par_q   <= par_d;
         erro_q  <= erro_d;
         tem_q   <= tem_d;
      end
   end

   assign dados_ascii = dados_q;
   assign paridade_ok = par_q;
   assign erro_quadro = erro_q;
   assign tem_dado    = tem_q;
   assign pronto_rx   = pronto;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Directed bench for the 7O1 receiver at 16 clocks per bit: drives whole frames
// on the line and checks the delivered character, flags and handshake.
module tb_rx_serial_7o1;

   localparam int CPB = 16;

   logic       clock;
   logic       reset;
   logic       dado_serial;
   logic       recebe_dado;
   logic [6:0] dados_ascii;
   logic       paridade_ok;
   logic       erro_quadro;
   logic       pronto_rx;
   logic       tem_dado;
   logic [3:0] db_estado;

   int n_checks = 0;
   int n_fail   = 0;
   int pronto_cnt = 0;
   int pronto_ref;

   rx_serial_7o1 #(.CLKS_PER_BIT(CPB), .TIMER_W(5)) dut (
      .clock       (clock),
      .reset       (reset),
      .dado_serial (dado_serial),
      .recebe_dado (recebe_dado),
      .dados_ascii (dados_ascii),
      .paridade_ok (paridade_ok),
      .erro_quadro (erro_quadro),
      .pronto_rx   (pronto_rx),
      .tem_dado    (tem_dado),
      .db_estado   (db_estado)
   );

   // clock / reset
   initial clock = 1'b0;
   always #5 clock = ~clock;

   always @(negedge clock) if (pronto_rx) pronto_cnt++;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   task automatic bit_out(input logic b);
      dado_serial = b;
      idle(CPB);
   endtask

   task automatic send_frame(input logic [6:0] d, input logic par, input logic stop);
      bit_out(1'b0);
      for (int i = 0; i < 7; i++) bit_out(d[i]);
      bit_out(par);
      bit_out(stop);
      dado_serial = 1'b1;
   endtask

   task automatic ack();
      recebe_dado = 1'b1;
      idle(1);
      recebe_dado = 1'b0;
      idle(2);
   endtask

   initial begin
      reset       = 1'b0;
      dado_serial = 1'b1;
      recebe_dado = 1'b0;
      idle(5);
      check("reset_db", db_estado, 4'h0);
      check("reset_dados", dados_ascii, 7'h00);
      check("reset_flags", {paridade_ok, erro_quadro, pronto_rx, tem_dado}, 4'b0000);
      reset = 1'b1;
      idle(100);
      check("idle_db", db_estado, 4'h0);
      check("idle_tem", tem_dado, 1'b0);

      // 'A' with correct parity and stop
      pronto_ref = pronto_cnt;
      send_frame(7'h41, 1'b1, 1'b1);
      idle(20);
      check("A_pronto", pronto_cnt - pronto_ref, 1);
      check("A_dados", dados_ascii, 7'h41);
      check("A_par", paridade_ok, 1'b1);
      check("A_erro", erro_quadro, 1'b0);
      check("A_tem", tem_dado, 1'b1);
      check("A_db", db_estado, 4'h6);
      ack();
      check("A_tem_ack", tem_dado, 1'b0);
      check("A_db_ack", db_estado, 4'h0);

      // 0x41 with wrong parity bit
      send_frame(7'h41, 1'b0, 1'b1);
      idle(20);
      check("badpar_dados", dados_ascii, 7'h41);
      check("badpar_par", paridade_ok, 1'b0);
      check("badpar_erro", erro_quadro, 1'b0);
      check("badpar_tem", tem_dado, 1'b1);
      ack();

      // 'C' with correct parity but stop bit low
      pronto_ref = pronto_cnt;
      send_frame(7'h43, 1'b0, 1'b0);
      idle(40);
      check("badstop_pronto", pronto_cnt - pronto_ref, 1);
      check("badstop_dados", dados_ascii, 7'h43);
      check("badstop_par", paridade_ok, 1'b1);
      check("badstop_erro", erro_quadro, 1'b1);
      ack();
      check("badstop_db", db_estado, 4'h0);

      // short low glitch must be rejected at the start-bit sample
      pronto_ref = pronto_cnt;
      dado_serial = 1'b0;
      idle(4);
      dado_serial = 1'b1;
      idle(40);
      check("glitch_pronto", pronto_cnt - pronto_ref, 0);
      check("glitch_db", db_estado, 4'h0);
      check("glitch_dados", dados_ascii, 7'h43);
      check("glitch_erro", erro_quadro, 1'b1);
      check("glitch_tem", tem_dado, 1'b0);

      // back-to-back frames without acknowledge
      pronto_ref = pronto_cnt;
      send_frame(7'h41, 1'b1, 1'b1);
      send_frame(7'h5A, 1'b1, 1'b1);
      idle(20);
      check("b2b_pronto", pronto_cnt - pronto_ref, 2);
      check("b2b_dados", dados_ascii, 7'h5A);
      check("b2b_par", paridade_ok, 1'b1);
      check("b2b_erro", erro_quadro, 1'b0);
      check("b2b_tem", tem_dado, 1'b1);
      ack();

      // reset in the middle of data bit 4 of 0x30
      dado_serial = 1'b0;
      idle(CPB);
      for (int i = 0; i < 4; i++) begin
         dado_serial = (7'h30 >> i) & 7'h01;
         idle(CPB);
      end
      dado_serial = 1'b1;
      idle(CPB / 2);
      reset = 1'b0;
      #1;
      check("midrst_dados", dados_ascii, 7'h00);
      check("midrst_flags", {paridade_ok, erro_quadro, pronto_rx, tem_dado}, 4'b0000);
      check("midrst_db", db_estado, 4'h0);
      idle(5);
      reset = 1'b1;
      idle(40);
      check("postrst_db", db_estado, 4'h0);
      pronto_ref = pronto_cnt;
      send_frame(7'h30, 1'b1, 1'b1);
      idle(20);
      check("postrst_pronto", pronto_cnt - pronto_ref, 1);
      check("postrst_dados", dados_ascii, 7'h30);
      check("postrst_par", paridade_ok, 1'b1);
      check("postrst_erro", erro_quadro, 1'b0);
      check("postrst_tem", tem_dado, 1'b1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
